display_in: RTL and testbench

- Receiving end of the serial 7-segment link driven by display_out.
- Samples the serial data line on rising edges of the derived shift clock and reassembles the 32-bit segment word.
- On the latch strobe, decodes each segment byte back to BCD and reports per-digit errors.
- Used as the bench/loopback checker for the display path and as the model of the external shift-register/driver.

---
 rtl/display_in.sv | 147 ++++++++++++++
 tb/tb_display_in.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/display_in.sv
// Serial 7-segment link receiver: reassembles the 32-bit segment word from
// ser_clk/ser_data, then decodes it to BCD with per-digit error flags on ser_latch.
module display_in #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ser_clk,
  input  logic        ser_data,
  input  logic        ser_latch,
  output logic [31:0] segment_data,
  output logic [15:0] bcd_out,
  output logic [3:0]  dp_out,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        overrun
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic        ser_clk_q, ser_clk_d;
  logic        ser_latch_q, ser_latch_d;
  logic [31:0] sr_q, sr_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0] seg_q, seg_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  dp_q, dp_d;
  logic [3:0]  derr_q, derr_d;
  logic        fv_q, fv_d;
  logic        fe_q, fe_d;
  logic        ovr_q, ovr_d;

  logic        rise_clk;
  logic        rise_latch;
  logic [31:0] sr_shift;
  logic [5:0]  cnt_next;

  // Returns {err, digit}; the decimal-point bit is masked off before matching.
  function automatic logic [4:0] decode_seg(input logic [7:0] b);
    case ({b[7:1], 1'b0})
      8'hFC:   return 5'h00;
      8'h60:   return 5'h01;
      8'hDA:   return 5'h02;
      8'hF2:   return 5'h03;
      8'h66:   return 5'h04;
      8'hB6:   return 5'h05;
      8'hBE:   return 5'h06;
      8'hE0:   return 5'h07;
      8'hFE:   return 5'h08;
      8'hF6:   return 5'h09;
      8'h02:   return 5'h1F;
      default: return 5'h1E;
    endcase
  endfunction

  assign rise_clk   = ser_clk & ~ser_clk_q;
  assign rise_latch = ser_latch & ~ser_latch_q;

  always_comb begin
    ser_clk_d   = ser_clk;
    ser_latch_d = ser_latch;
    seg_d       = seg_q;
    bcd_d       = bcd_q;
    dp_d        = dp_q;
    derr_d      = derr_q;
    ovr_d       = ovr_q;
    fv_d        = 1'b0;
    fe_d        = 1'b0;

    sr_shift = rise_clk ? {ser_data, sr_q[31:1]} : sr_q;
    cnt_next = cnt_q;
    if (rise_clk && (cnt_q != 6'd63)) begin
      cnt_next = cnt_q + 6'd1;
    end
    sr_d  = sr_shift;
    cnt_d = cnt_next;

    // Idle watchdog: a stalled partial frame is silently dropped.
    if (rise_clk || (cnt_q == 6'd0)) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      tmo_d = '0;
      cnt_d = 6'd0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    // A bit arriving with the latch is counted before the frame is judged.
    if (rise_latch) begin
      cnt_d = 6'd0;
      tmo_d = '0;
      if (cnt_next < 6'd32) begin
        fe_d = 1'b1;
      end else begin
        fv_d  = 1'b1;
        seg_d = sr_shift;
        ovr_d = (cnt_next > 6'd32);
        for (int i = 0; i < 4; i++) begin
          {derr_d[i], bcd_d[4*i +: 4]} = decode_seg(sr_shift[8*i +: 8]);
          dp_d[i] = sr_shift[8*i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ser_clk_q   <= 1'b0;
      ser_latch_q <= 1'b0;
      sr_q        <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      seg_q       <= '0;
      bcd_q       <= '0;
      dp_q        <= '0;
      derr_q      <= '0;
      fv_q        <= 1'b0;
      fe_q        <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      ser_clk_q   <= ser_clk_d;
      ser_latch_q <= ser_latch_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      seg_q       <= seg_d;
      bcd_q       <= bcd_d;
      dp_q        <= dp_d;
      derr_q      <= derr_d;
      fv_q        <= fv_d;
      fe_q        <= fe_d;
      ovr_q       <= ovr_d;
    end
  end

  assign segment_data = seg_q;
  assign bcd_out      = bcd_q;
  assign dp_out       = dp_q;
  assign digit_err    = derr_q;
  assign frame_valid  = fv_q;
  assign frame_err    = fe_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_display_in.sv
// Scoreboard bench for display_in: frames are driven bit-serially and the
// expected accept/error result of each latch is queued and checked on its pulse.
module tb_display_in;

  logic        clk = 1'b0;
  logic        rst;
  logic        ser_clk;
  logic        ser_data;
  logic        ser_latch;
  logic [31:0] segment_data;
  logic [15:0] bcd_out;
  logic [3:0]  dp_out;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        frame_err;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        fv;
    logic        fe;
    logic [31:0] seg;
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic [3:0]  derr;
    logic        ovr;
  } exp_t;

  exp_t sb[$];
  exp_t held;
  logic prev_pulse = 1'b0;

  display_in #(.TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .rst(rst), .ser_clk(ser_clk), .ser_data(ser_data),
    .ser_latch(ser_latch), .segment_data(segment_data), .bcd_out(bcd_out),
    .dp_out(dp_out), .digit_err(digit_err), .frame_valid(frame_valid),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One ser_clk period of 102 clk, high for the first half.
  task automatic sendBit(input logic b);
    @(posedge clk); #1;
    ser_data = b;
    ser_clk  = 1'b1;
    repeat (51) @(posedge clk);
    #1 ser_clk = 1'b0;
    repeat (50) @(posedge clk);
  endtask

  task automatic applyStimulus(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) sendBit(w[i]);
  endtask

  task automatic expectAccept(input logic [31:0] seg, input logic [15:0] bcd,
                              input logic [3:0] dp, input logic [3:0] derr, input logic ovr);
    exp_t e;
    e.fv = 1'b1; e.fe = 1'b0; e.seg = seg; e.bcd = bcd; e.dp = dp; e.derr = derr; e.ovr = ovr;
    held = e;
    sb.push_back(e);
  endtask

  task automatic expectError();
    exp_t e;
    e = held;
    e.fv = 1'b0;
    e.fe = 1'b1;
    sb.push_back(e);
  endtask

  task automatic pulseLatch();
    @(posedge clk); #1 ser_latch = 1'b1;
    @(posedge clk); #2;
    checkOutput("latch_latency", {31'd0, frame_valid | frame_err}, 32'd1);
    repeat (3) @(posedge clk);
    #1 ser_latch = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_seg"}, segment_data, 32'd0);
    checkOutput({tag, "_bcd"}, {16'd0, bcd_out}, 32'd0);
    checkOutput({tag, "_dp"}, {28'd0, dp_out}, 32'd0);
    checkOutput({tag, "_derr"}, {28'd0, digit_err}, 32'd0);
    checkOutput({tag, "_pulses"}, {30'd0, frame_valid, frame_err}, 32'd0);
    checkOutput({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
  endtask

  // Scoreboard consumer: every result pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (frame_valid || frame_err) begin
      checkOutput("pulse_width", {31'd0, prev_pulse}, 32'd0);
      checkOutput("sb_pending", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("kind", {30'd0, frame_valid, frame_err}, {30'd0, e.fv, e.fe});
        checkOutput("segment_data", segment_data, e.seg);
        checkOutput("bcd_out", {16'd0, bcd_out}, {16'd0, e.bcd});
        checkOutput("dp_out", {28'd0, dp_out}, {28'd0, e.dp});
        checkOutput("digit_err", {28'd0, digit_err}, {28'd0, e.derr});
        checkOutput("overrun", {31'd0, overrun}, {31'd0, e.ovr});
      end
    end
    prev_pulse = frame_valid | frame_err;
  end

  initial begin
    rst = 1'b1; ser_clk = 1'b0; ser_data = 1'b0; ser_latch = 1'b0;
    held = '{fv: 1'b0, fe: 1'b0, seg: 32'd0, bcd: 16'd0, dp: 4'd0, derr: 4'd0, ovr: 1'b0};
    repeat (4) @(posedge clk);
    #2 checkAllZero("reset");
    #1 rst = 1'b0;

    $display("[TB] digits 1234");
    applyStimulus(32'h60DAF266, 32);
    expectAccept(32'h60DAF266, 16'h1234, 4'b0000, 4'b0000, 1'b0);
    pulseLatch();

    $display("[TB] zeros with dash and dp");
    applyStimulus(32'hFCFCFC03, 32);
    expectAccept(32'hFCFCFC03, 16'h000F, 4'b0001, 4'b0001, 1'b0);
    pulseLatch();

    $display("[TB] short frame then recovery");
    applyStimulus(32'h60DAF266, 20);
    expectError();
    pulseLatch();
    applyStimulus(32'hF2FC6067, 32);
    expectAccept(32'hF2FC6067, 16'h3014, 4'b0001, 4'b0000, 1'b0);
    pulseLatch();

    $display("[TB] overrun frame then clean frame");
    applyStimulus(32'h0000_0002, 2);
    applyStimulus(32'hB6BEE0FE, 32);
    expectAccept(32'hB6BEE0FE, 16'h5678, 4'b0000, 4'b0000, 1'b1);
    pulseLatch();
    applyStimulus(32'h60DAF211, 32);
    expectAccept(32'h60DAF211, 16'h123E, 4'b0001, 4'b0001, 1'b0);
    pulseLatch();

    $display("[TB] timeout discards partial frame");
    applyStimulus(32'h0000_03FF, 10);
    repeat (1100) @(posedge clk);
    applyStimulus(32'hF6FEE0BE, 32);
    expectAccept(32'hF6FEE0BE, 16'h9876, 4'b0000, 4'b0000, 1'b0);
    pulseLatch();
    applyStimulus(32'h0000_0155, 10);
    repeat (1100) @(posedge clk);
    expectError();
    pulseLatch();

    $display("[TB] reset mid-frame");
    applyStimulus(32'hFFFF_FFFF, 16);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #2;
    checkAllZero("midreset");
    #1 rst = 1'b0;
    held = '{fv: 1'b0, fe: 1'b0, seg: 32'd0, bcd: 16'd0, dp: 4'd0, derr: 4'd0, ovr: 1'b0};
    expectError();
    pulseLatch();

    $display("[TB] last bit coincides with latch");
    applyStimulus(32'hE066B6F3, 31);
    @(posedge clk); #1;
    ser_data  = 1'b1;
    ser_clk   = 1'b1;
    ser_latch = 1'b1;
    expectAccept(32'hE066B6F3, 16'h7453, 4'b0001, 4'b0000, 1'b0);
    @(posedge clk); #2;
    checkOutput("coincident_latency", {31'd0, frame_valid}, 32'd1);
    repeat (50) @(posedge clk);
    #1 ser_clk = 1'b0; ser_latch = 1'b0;
    repeat (10) @(posedge clk);

    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
